// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and defaults for the multi-cycle shift sequencer.
// Holds the op encodings, FSM state encoding and datapath width defaults.
package shift_seq_ctrl_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle between decoder/control and the shift sequencer.
// The handshake is start/busy/done. start_i is sampled only while the sequencer is idle.
// busy_o is high while shifting. done_o pulses for one cycle, and data_o then holds
// until the next completion.
interface shift_seq_ctrl_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start_i;
    logic [1:0]         op_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic [WIDTH-1:0]   data_i;
    logic               busy_o;
    logic               done_o;
    logic [WIDTH-1:0]   data_o;

    modport master (
        output start_i, op_i, shamt_i, data_i,
        input  busy_o, done_o, data_o
    );

    modport slave (
        input  start_i, op_i, shamt_i, data_i,
        output busy_o, done_o, data_o
    );
endinterface

// File: rtl/shift_seq_ctrl_step.sv
// Combinational single step of the sequencer: shift by 1 or 2 with op-specific fill.
// The reserved op passes the operand through unchanged.
module shift_step_unit
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] operand_i,
    input  op_e              op_i,
    input  logic             step_two_i,
    output logic [WIDTH-1:0] result_o
);

    logic sign;
    assign sign = operand_i[WIDTH-1];

    always_comb begin
        result_o = operand_i;
        case (op_i)
            OP_SLL: result_o = step_two_i ? {operand_i[WIDTH-3:0], 2'b00}
                                          : {operand_i[WIDTH-2:0], 1'b0};
            OP_SRL: result_o = step_two_i ? {2'b00, operand_i[WIDTH-1:2]}
                                          : {1'b0, operand_i[WIDTH-1:1]};
            // Sign fills both vacated bits of a 2-bit step.
            OP_SRA: result_o = step_two_i ? {{2{sign}}, operand_i[WIDTH-1:2]}
                                          : {sign, operand_i[WIDTH-1:1]};
            default: result_o = operand_i;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer controller: owns the FSM, the remaining-count counter, the operand
// register and the result register. It applies one shift_step_unit step per cycle.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    shift_seq_ctrl_if.slave     bus,
    output state_t              state_o
);

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   data_o_q, data_o_d;

    logic               step_two;
    logic [WIDTH-1:0]   step_out;
    logic [SHAMT_W-1:0] rem_next;

    assign step_two = (rem_q >= SHAMT_W'(2));
    assign rem_next = rem_q - (step_two ? SHAMT_W'(2) : SHAMT_W'(1));

    shift_step_unit #(.WIDTH(WIDTH)) u_step (
        .operand_i  (opnd_q),
        .op_i       (op_q),
        .step_two_i (step_two),
        .result_o   (step_out)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            opnd_q   <= '0;
            op_q     <= OP_SLL;
            data_o_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            data_o_q <= data_o_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        data_o_d = data_o_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    opnd_d = bus.data_i;
                    op_d   = op_e'(bus.op_i);
                    if (bus.shamt_i == '0 || op_e'(bus.op_i) == OP_RSV) begin
                        rem_d    = '0;
                        data_o_d = bus.data_i;
                        state_d  = DONE;
                    end else begin
                        rem_d   = bus.shamt_i;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                opnd_d = step_out;
                rem_d  = rem_next;
                if (rem_next == '0) begin
                    data_o_d = step_out;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy_o = (state_q == SHIFT);
    assign bus.done_o = (state_q == DONE);
    assign bus.data_o = data_o_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: table-driven vectors with a scoreboard queue,
// plus hand-written handshake and mid-operation reset sequences.
module tb_shift_seq_ctrl;
    import shift_seq_ctrl_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  shamt;
        logic [31:0] data;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;
    int     tests;
    int     fails;
    logic [31:0] exp_q[$];
    vec_t   vecs[16];

    shift_seq_ctrl_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    shift_seq_ctrl #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .bus     (bus.slave),
        .state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(logic [1:0] op, logic [4:0] sh, logic [31:0] d);
        case (op)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return 32'($signed(d) >>> sh);
            default: return d;
        endcase
    endfunction

    function automatic int model_lat(logic [1:0] op, logic [4:0] sh);
        if (sh == 5'd0 || op == 2'b11) return 1;
        return 1 + (int'(sh) + 1) / 2;
    endfunction

    function automatic vec_t mk(logic [1:0] op, logic [4:0] sh, logic [31:0] d,
                                logic [31:0] e, int l);
        vec_t v;
        v.op = op; v.shamt = sh; v.data = d; v.exp = e; v.lat = l;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(logic [1:0] op, logic [4:0] sh, logic [31:0] d);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.shamt_i = sh;
        bus.data_i  = d;
    endtask

    // Drive one request, then follow it to done_o within a bounded cycle budget.
    task automatic run_op(vec_t v, string name);
        logic [31:0] held;
        logic        exp_busy;
        logic [31:0] e;
        int          cyc;
        bit          seen;
        @(negedge clk);
        drive_req(v.op, v.shamt, v.data);
        exp_q.push_back(v.exp);
        held     = bus.data_o;
        exp_busy = (v.lat > 1);
        @(posedge clk);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus.start_i = 1'b0;
            bus.data_i  = $urandom;
            if (bus.done_o === 1'b1) seen = 1;
            else begin
                chk({name, "_busy"}, 32'(bus.busy_o), 32'(exp_busy));
                chk({name, "_hold"}, bus.data_o, held);
            end
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL %s_timeout: no done_o within 40 cycles", name);
            exp_q.delete();
        end else begin
            chk({name, "_lat"}, 32'(cyc), 32'(v.lat));
            e = exp_q.pop_front();
            chk({name, "_data"}, bus.data_o, e);
            @(negedge clk);
            chk({name, "_pulse"}, 32'(bus.done_o), 32'd0);
            chk({name, "_keep"}, bus.data_o, e);
        end
    endtask

    initial begin
        int          cyc;
        logic [31:0] e;
        logic [31:0] held;
        logic [1:0]  rop;
        logic [4:0]  rsh;
        logic [31:0] rd;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.shamt_i = 5'd0;
        bus.data_i  = 32'h0;

        vecs[0]  = mk(2'b00, 5'd5,  32'h0000_0001, 32'h0000_0020, 4);
        vecs[1]  = mk(2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 17);
        vecs[2]  = mk(2'b10, 5'd3,  32'h7000_0000, 32'h0E00_0000, 3);
        vecs[3]  = mk(2'b01, 5'd4,  32'h8000_0000, 32'h0800_0000, 3);
        vecs[4]  = mk(2'b01, 5'd1,  32'h8000_0000, 32'h4000_0000, 2);
        vecs[5]  = mk(2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        vecs[6]  = mk(2'b11, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        vecs[7]  = mk(2'b10, 5'd2,  32'h8000_0000, 32'hE000_0000, 2);
        vecs[8]  = mk(2'b00, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 17);
        vecs[9]  = mk(2'b10, 5'd30, 32'h4000_0000, 32'h0000_0001, 16);
        for (int i = 10; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            rsh = 5'($urandom_range(0, 31));
            rd  = $urandom;
            vecs[i] = mk(rop, rsh, rd, model(rop, rsh, rd), model_lat(rop, rsh));
        end

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy",  32'(bus.busy_o), 32'd0);
        chk("rst_done",  32'(bus.done_o), 32'd0);
        chk("rst_data",  bus.data_o, 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // handshake: start held high with changing inputs during SHIFT
        @(negedge clk);
        drive_req(2'b00, 5'd4, 32'h0000_0003);
        exp_q.push_back(32'h0000_0030);
        held = bus.data_o;
        @(posedge clk);
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.done_o === 1'b1) break;
            chk("hs_hold", bus.data_o, held);
            bus.data_i  = $urandom;
            bus.op_i    = 2'($urandom_range(0, 3));
            bus.shamt_i = 5'($urandom_range(0, 31));
        end
        chk("hs_lat1", 32'(cyc), 32'd3);
        e = exp_q.pop_front();
        chk("hs_data1", bus.data_o, e);
        drive_req(2'b01, 5'd2, 32'h0000_0005);
        exp_q.push_back(32'h0000_0001);
        held = bus.data_o;
        @(negedge clk);
        chk("hs_idle_busy",  32'(bus.busy_o), 32'd0);
        chk("hs_idle_done",  32'(bus.done_o), 32'd0);
        chk("hs_idle_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("hs_busy2", 32'(bus.busy_o), 32'd1);
        chk("hs_stable", bus.data_o, held);
        @(negedge clk);
        chk("hs_done2", 32'(bus.done_o), 32'd1);
        e = exp_q.pop_front();
        chk("hs_data2", bus.data_o, e);

        // reset mid-SHIFT, asserted between clock edges
        @(negedge clk);
        drive_req(2'b10, 5'd31, 32'h8000_0000);
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  32'(bus.busy_o), 32'd0);
        chk("arst_done",  32'(bus.done_o), 32'd0);
        chk("arst_data",  bus.data_o, 32'h0);
        chk("arst_state", 32'(dbg_state), 32'(IDLE));
        repeat (2) begin
            @(negedge clk);
            chk("arst_nodone", 32'(bus.done_o), 32'd0);
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("post_rst_nodone", 32'(bus.done_o), 32'd0);
        end
        run_op(mk(2'b00, 5'd2, 32'h0000_0001, 32'h0000_0004, 2), "post_rst");

        chk("q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
